// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: DEPTH-stage EX->MEM register with valid, stall, flush and async reset.
// Define STAGE_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_m2,
  input  logic              in_memwrite,
  input  logic              in_memread,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [ADDR_W-1:0] in_regwradd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_m2,
  output logic              out_memwrite,
  output logic              out_memread,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic [ADDR_W-1:0] out_regwradd
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);
  typedef struct packed {
    logic              valid;
    logic              memwrite;
    logic              memread;
    logic              memtoreg;
    logic              regwrite;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] m2;
    logic [ADDR_W-1:0] regwradd;
  } stage_t;
  stage_t [DEPTH-1:0] st;
  stage_t             in_st;
  // controls are gated by valid on entry so a bubble can never write
  assign in_st = '{in_valid, in_valid & in_memwrite, in_valid & in_memread,
                   in_valid & in_memtoreg, in_valid & in_regwrite,
                   in_b, in_alu_out, in_m2, in_regwradd};
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) st <= '0;
    else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        st[i].valid    <= 1'b0;
        st[i].memwrite <= 1'b0;
        st[i].memread  <= 1'b0;
        st[i].memtoreg <= 1'b0;
        st[i].regwrite <= 1'b0;
      end
    end else if (!stall) begin
      st[0] <= in_st;
      for (int i = 1; i < DEPTH; i++) st[i] <= st[i-1];
    end
  end
  assign out_valid    = st[DEPTH-1].valid;
  assign out_b        = st[DEPTH-1].b;
  assign out_alu_out  = st[DEPTH-1].alu_out;
  assign out_m2       = st[DEPTH-1].m2;
  assign out_memwrite = st[DEPTH-1].memwrite;
  assign out_memread  = st[DEPTH-1].memread;
  assign out_memtoreg = st[DEPTH-1].memtoreg;
  assign out_regwrite = st[DEPTH-1].regwrite;
  assign out_regwradd = st[DEPTH-1].regwradd;
`ifdef STAGE_PERF_CNT_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: checks DEPTH=1,2,3 instances side by side against a queue scoreboard.
module tb_ex_mem_pipe_reg;
  localparam int DW = 8;
  localparam int AW = 3;
  logic clk1 = 0, rst_n = 1, stall = 0, flush = 0, in_valid = 0;
  logic [DW-1:0] in_b = 0, in_alu_out = 0, in_m2 = 0;
  logic in_memwrite = 0, in_memread = 0, in_memtoreg = 0, in_regwrite = 0;
  logic [AW-1:0] in_regwradd = 0;
  logic ov [3], ow [3], orr [3], ot [3], org [3];
  logic [DW-1:0] ob [3], oa [3], om [3];
  logic [AW-1:0] orad [3];
`ifdef STAGE_PERF_CNT_EN
  logic [15:0] sc [3], fc [3];
`endif
  int tot = 0, bad = 0;

  always #5 clk1 = ~clk1;

  for (genvar g = 0; g < 3; g++) begin : gd
    ex_mem_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(g + 1)) dut (
      .clk1(clk1), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_b(in_b), .in_alu_out(in_alu_out), .in_m2(in_m2),
      .in_memwrite(in_memwrite), .in_memread(in_memread), .in_memtoreg(in_memtoreg),
      .in_regwrite(in_regwrite), .in_regwradd(in_regwradd),
      .out_valid(ov[g]), .out_b(ob[g]), .out_alu_out(oa[g]), .out_m2(om[g]),
      .out_memwrite(ow[g]), .out_memread(orr[g]), .out_memtoreg(ot[g]),
      .out_regwrite(org[g]), .out_regwradd(orad[g])
`ifdef STAGE_PERF_CNT_EN
      , .stall_cnt(sc[g]), .flush_cnt(fc[g])
`endif
    );
  end

  typedef struct packed {
    logic          v;
    logic [3:0]    c;
    logic [DW-1:0] b, a, m;
    logic [AW-1:0] r;
  } ent_t;

  typedef struct {
    logic s, f, v;
    logic [7:0] a, b;
    logic [3:0] c;
    logic [2:0] r;
    logic ev;
    logic [7:0] ea;
    logic [3:0] ec;
  } vec_t;

  // scoreboard: q[g][0] is the last stage, the back is stage 0
  ent_t q [3][$];
`ifdef STAGE_PERF_CNT_EN
  int sce = 0, fce = 0;
`endif

  function automatic ent_t act(int g);
    return {ov[g], ow[g], orr[g], ot[g], org[g], ob[g], oa[g], om[g], orad[g]};
  endfunction

  task automatic chk(int g);
    ent_t e = q[g][0];
    ent_t a = act(g);
    tot++;
    if (a.v !== e.v || a.c !== e.c || (e.v && (a.b !== e.b || a.a !== e.a || a.m !== e.m || a.r !== e.r))) begin
      bad++;
      $display("FAIL scoreboard d%0d: got %h required %h", g + 1, a, e);
    end
  endtask

  task automatic exp_e(string nm, int g, logic ev, logic [7:0] ea, logic [3:0] ec);
    ent_t a = act(g);
    tot++;
    if (a.v !== ev || a.c !== (ev ? ec : 4'h0) || (ev && a.a !== ea)) begin
      bad++;
      $display("FAIL %s d%0d: got v=%b c=%b alu=%h required v=%b c=%b alu=%h",
               nm, g + 1, a.v, a.c, a.a, ev, ev ? ec : 4'h0, ea);
    end
  endtask

  task automatic do_reset();
    stall = 0; flush = 0; in_valid = 0;
    rst_n = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      q[g].delete();
      repeat (g + 1) q[g].push_back('0);
      tot++;
      if (act(g) !== '0) begin
        bad++;
        $display("FAIL async_reset d%0d: got %h required 0", g + 1, act(g));
      end
    end
`ifdef STAGE_PERF_CNT_EN
    sce = 0; fce = 0;
`endif
    @(negedge clk1);
    rst_n = 1;
  endtask

  task automatic step(input logic s, input logic f, input logic v, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] c, input logic [2:0] r);
    ent_t e, t;
    stall = s; flush = f; in_valid = v; in_alu_out = a; in_b = b; in_m2 = a ^ 8'h5A;
    {in_memwrite, in_memread, in_memtoreg, in_regwrite} = c;
    in_regwradd = r;
    e = '{v, v ? c : 4'h0, b, a, a ^ 8'h5A, r};
    for (int g = 0; g < 3; g++) begin
      if (f) begin
        for (int i = 0; i < q[g].size(); i++) begin
          t = q[g][i]; t.v = 0; t.c = 0; q[g][i] = t;
        end
      end else if (!s) begin
        q[g].push_back(e);
        void'(q[g].pop_front());
      end
    end
`ifdef STAGE_PERF_CNT_EN
    if (f && fce < 65535) fce++;
    if (s && !f && sce < 65535) sce++;
`endif
    @(posedge clk1);
    #1;
    for (int g = 0; g < 3; g++) chk(g);
  endtask

  vec_t tv [8];
  logic [7:0] sa [6], ea2 [6];
  logic ss [6], ev2 [6];

  initial begin
    tv[0] = '{0, 0, 1, 8'h3C, 8'hA5, 4'b0001, 3'd5, 1, 8'h3C, 4'b0001};
    tv[1] = '{0, 0, 1, 8'h50, 8'h11, 4'b1000, 3'd1, 1, 8'h50, 4'b1000};
    tv[2] = '{0, 0, 0, 8'h60, 8'h22, 4'b1111, 3'd2, 0, 8'h00, 4'b0000};
    tv[3] = '{0, 0, 1, 8'h70, 8'h33, 4'b0110, 3'd3, 1, 8'h70, 4'b0110};
    tv[4] = '{1, 0, 1, 8'h80, 8'h44, 4'b1111, 3'd4, 1, 8'h70, 4'b0110};
    tv[5] = '{1, 1, 1, 8'h90, 8'h55, 4'b1111, 3'd6, 0, 8'h00, 4'b0000};
    tv[6] = '{0, 1, 1, 8'hA0, 8'h66, 4'b1111, 3'd7, 0, 8'h00, 4'b0000};
    tv[7] = '{0, 0, 1, 8'hB0, 8'h77, 4'b0101, 3'd7, 1, 8'hB0, 4'b0101};
    #2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tv[i].s, tv[i].f, tv[i].v, tv[i].a, tv[i].b, tv[i].c, tv[i].r);
      exp_e($sformatf("vec%0d", i), 0, tv[i].ev, tv[i].ea, tv[i].ec);
      if (i == 0) begin
        tot++;
        if (ob[0] !== 8'hA5 || orad[0] !== 3'd5) begin
          bad++;
          $display("FAIL vec0_fields: got b=%h addr=%0d required b=a5 addr=5", ob[0], orad[0]);
        end
      end
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, i < 4, 8'(i + 1), 8'hC0, 4'b0001, 3'd1);
      exp_e("d3_stream", 2, i >= 2, 8'(i - 1), 4'b0001);
    end

    do_reset();
    sa  = '{8'h10, 8'h11, 8'hEE, 8'hEF, 8'h12, 8'h00};
    ss  = '{0, 0, 1, 1, 0, 0};
    ev2 = '{0, 1, 1, 1, 1, 1};
    ea2 = '{8'h00, 8'h10, 8'h10, 8'h10, 8'h11, 8'h12};
    for (int i = 0; i < 6; i++) begin
      step(ss[i], 0, i != 5, sa[i], 8'h0F, 4'b0010, 3'd2);
      exp_e("d2_stall", 1, ev2[i], ea2[i], 4'b0010);
    end

    do_reset();
    step(0, 0, 1, 8'hA1, 8'h01, 4'b1000, 3'd1);
    step(0, 0, 1, 8'hA2, 8'h02, 4'b1000, 3'd2);
    step(1, 1, 1, 8'hA3, 8'h03, 4'b1000, 3'd3);
    for (int g = 0; g < 3; g++) exp_e("flush_kill", g, 0, 8'h00, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, k == 0, 8'h77, 8'h04, 4'b0001, 3'd4);
      exp_e("flush_77", 2, k == 2, 8'h77, 4'b0001);
    end

    step(0, 0, 1, 8'h5A, 8'h05, 4'b0011, 3'd6);
    exp_e("pre_reset", 0, 1, 8'h5A, 4'b0011);
    do_reset();

    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0,
           8'($urandom), 8'($urandom), 4'($urandom), 3'($urandom));

`ifdef STAGE_PERF_CNT_EN
    do_reset();
    repeat (3) step(1, 0, 1, 8'h11, 8'h22, 4'b1111, 3'd1);
    repeat (2) step(0, 1, 1, 8'h33, 8'h44, 4'b1111, 3'd2);
    for (int g = 0; g < 3; g++) begin
      tot++;
      if (sc[g] !== 16'(sce) || fc[g] !== 16'(fce) || sce != 3 || fce != 2) begin
        bad++;
        $display("FAIL perf_cnt d%0d: got stall=%0d flush=%0d required stall=3 flush=2", g + 1, sc[g], fc[g]);
      end
    end
    stall = 1; flush = 0;
    repeat (70000) @(posedge clk1);
    #1;
    for (int g = 0; g < 3; g++) begin
      tot++;
      if (sc[g] !== 16'hFFFF || fc[g] !== 16'd2) begin
        bad++;
        $display("FAIL perf_sat d%0d: got stall=%h flush=%0d required stall=ffff flush=2", g + 1, sc[g], fc[g]);
      end
    end
    stall = 0;
`endif

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
